// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the streamed instruction memory.
//   load_state_t : loader FSM states
//   WORD_W       : default fetch word width in bits
//   in_range     : true when [addr, addr+nbytes) lies inside [0, depth)
package instr_mem_pkg;

  typedef enum logic [0:0] {
    LS_IDLE = 1'b0,
    LS_LOAD = 1'b1
  } load_state_t;

  localparam int unsigned DEF_WORD_BYTES = 4;
  localparam int unsigned WORD_W         = 8 * DEF_WORD_BYTES;

  // One extra bit of headroom so addr + nbytes can never wrap into range.
  function automatic logic in_range(input logic [63:0] addr,
                                    input logic [63:0] nbytes,
                                    input logic [63:0] depth);
    return ({1'b0, addr} + {1'b0, nbytes}) <= {1'b0, depth};
  endfunction

endpackage

// File: rtl/byte_ram.sv
// Byte-wide storage with one synchronous write port and a word-wide
// combinational little-endian read.
//   clk     : write clock
//   wr_en   : write strobe
//   wr_addr : byte index written
//   wr_data : byte written
//   rd_addr : base byte index of the read
//   rd_data : {mem[rd_addr+WORD_BYTES-1], ..., mem[rd_addr]}; bytes past DEPTH read 0
module byte_ram #(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic                                         clk,
  input  logic                                         wr_en,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] wr_addr,
  input  logic [7:0]                                   wr_data,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] rd_addr,
  output logic [8*WORD_BYTES-1:0]                      rd_data
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [IdxW:0] idx;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A write landing in the same cycle is forwarded so a registered reader
  // observes write-then-read ordering.
  always_comb begin
    rd_data = '0;
    idx     = '0;
    for (int unsigned k = 0; k < WORD_BYTES; k++) begin
      idx = (IdxW + 1)'(rd_addr) + (IdxW + 1)'(k);
      if (idx < (IdxW + 1)'(DEPTH)) begin
        if (wr_en && (idx == {1'b0, wr_addr})) begin
          rd_data[8*k +: 8] = wr_data;
        end else begin
          rd_data[8*k +: 8] = mem[idx[IdxW-1:0]];
        end
      end
    end
  end

endmodule

// File: rtl/instr_mem_stream.sv
// Byte-addressed instruction memory with a byte-stream loader and a
// registered word fetch port.
//   clk, rst            : clock, asynchronous active-high reset
//   load_start          : begin a session (honoured in IDLE only)
//   load_base, load_len : first byte address and byte count of the session
//   ld_valid, ld_data   : incoming byte stream; ld_ready accepts
//   load_busy           : session in progress
//   load_done           : one-cycle pulse after a session ends
//   load_ovf            : sticky, a session byte fell outside DEPTH
//   fetch_req/addr      : word fetch at any byte address
//   fetch_valid/data    : result one cycle later, little-endian
//   fetch_fault         : result invalid (out of range or loader busy)
module instr_mem_stream
  import instr_mem_pkg::*;
#(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned WORD_BYTES = WORD_W / 8,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic [ADDR_W-1:0]       load_base,
  input  logic [ADDR_W-1:0]       load_len,
  input  logic                    ld_valid,
  input  logic [7:0]              ld_data,
  output logic                    ld_ready,
  output logic                    load_busy,
  output logic                    load_done,
  output logic                    load_ovf,
  input  logic                    fetch_req,
  input  logic [ADDR_W-1:0]       fetch_addr,
  output logic                    fetch_valid,
  output logic [8*WORD_BYTES-1:0] fetch_data,
  output logic                    fetch_fault
);

  localparam int unsigned IdxW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WordW = 8 * WORD_BYTES;

  load_state_t       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              fvalid_q, ffault_q;
  logic [WordW-1:0]  fdata_q;

  logic              hs;
  logic              last_byte;
  logic              ptr_ok;
  logic              wr_en;
  logic              fetch_ok;
  logic              fault_d;
  logic [WordW-1:0]  rd_data;

  assign hs        = ld_valid && (state_q == LS_LOAD);
  assign last_byte = hs && (rem_q == ADDR_W'(1));
  assign ptr_ok    = in_range(64'(ptr_q), 64'd1, 64'(DEPTH));
  assign wr_en     = hs && ptr_ok;
  assign fetch_ok  = in_range(64'(fetch_addr), 64'(WORD_BYTES), 64'(DEPTH));
  // The cycle carrying the final byte already counts as idle for fetches.
  assign fault_d   = !fetch_ok || ((state_q == LS_LOAD) && !last_byte);

  byte_ram #(
    .DEPTH      (DEPTH),
    .WORD_BYTES (WORD_BYTES)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (ptr_q[IdxW-1:0]),
    .wr_data (ld_data),
    .rd_addr (fetch_addr[IdxW-1:0]),
    .rd_data (rd_data)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LS_IDLE: if (load_start && (load_len != '0)) state_d = LS_LOAD;
      LS_LOAD: if (last_byte) state_d = LS_IDLE;
      default: state_d = LS_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    load_busy = (state_q == LS_LOAD);
    ld_ready  = load_busy;
  end

  // Loader datapath next state
  always_comb begin
    ptr_d  = ptr_q;
    rem_d  = rem_q;
    done_d = 1'b0;
    ovf_d  = ovf_q;
    unique case (state_q)
      LS_IDLE: begin
        if (load_start) begin
          ovf_d = 1'b0;
          if (load_len == '0) begin
            done_d = 1'b1;
          end else begin
            ptr_d = load_base;
            rem_d = load_len;
          end
        end
      end
      LS_LOAD: begin
        if (hs) begin
          ptr_d = ptr_q + ADDR_W'(1);
          rem_d = rem_q - ADDR_W'(1);
          if (!ptr_ok) ovf_d = 1'b1;
          if (last_byte) done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      rem_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      rem_q  <= rem_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
    end
  end

  // Fetch result registers; data holds while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fvalid_q <= 1'b0;
      ffault_q <= 1'b0;
      fdata_q  <= '0;
    end else begin
      fvalid_q <= fetch_req;
      ffault_q <= fetch_req && fault_d;
      if (fetch_req) begin
        fdata_q <= fault_d ? '0 : rd_data;
      end
    end
  end

  assign load_done   = done_q;
  assign load_ovf    = ovf_q;
  assign fetch_valid = fvalid_q;
  assign fetch_fault = ffault_q;
  assign fetch_data  = fdata_q;

endmodule

// File: doc/instr_mem_stream.md
Name: instr_mem_stream

Overview:
- Parametrised byte-addressed instruction memory for the single-cycle and multi-cycle RISC-V cores.
- Little-endian storage; each fetch returns WORD_BYTES bytes starting at any byte address.
- Replaces the combinational word-preload memory with two clocked interfaces:
  - a byte-stream loader FSM with valid/ready handshake, auto-incrementing address and length count;
  - a 1-cycle-latency synchronous fetch port with range-fault reporting.

Parameters:
- DEPTH, 1024, memory size in bytes (any value >= WORD_BYTES)
- WORD_BYTES, 4, bytes returned per fetch
- ADDR_W, 32, width of all address and length ports

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- load_start  input  1  request a load session (sampled in IDLE only)
- load_base  input  ADDR_W  first byte address of the session
- load_len  input  ADDR_W  number of bytes in the session
- ld_valid  input  1  stream byte valid
- ld_data  input  8  stream byte
- ld_ready  output  1  loader accepts a byte this cycle
- load_busy  output  1  loader is in LOAD
- load_done  output  1  one-cycle pulse when a session ends
- load_ovf  output  1  sticky: a session byte fell outside DEPTH
- fetch_req  input  1  fetch request
- fetch_addr  input  ADDR_W  byte address of the fetch
- fetch_valid  output  1  fetch result valid, one cycle after fetch_req
- fetch_data  output  8*WORD_BYTES  {mem[a+WB-1], ..., mem[a]}
- fetch_fault  output  1  qualifies fetch_valid: result is invalid

Behaviour:
- Reset values:
  - ld_ready, load_busy, load_done, load_ovf, fetch_valid, fetch_fault = 0.
  - fetch_data = 0.
  - FSM in IDLE; pointer and remaining counter = 0.
  - Memory contents are not cleared by reset. Simulation initial contents are all zero.
- FSM states are IDLE and LOAD. load_busy = (state == LOAD). ld_ready = (state == LOAD).
- IDLE with load_start=1 and load_len != 0:
  - latch ptr = load_base and rem = load_len;
  - clear load_ovf;
  - go to LOAD next cycle.
- IDLE with load_start=1 and load_len == 0:
  - stay in IDLE;
  - clear load_ovf;
  - pulse load_done in the next cycle.
- LOAD, on ld_valid & ld_ready:
  - if ptr < DEPTH, write mem[ptr] = ld_data; otherwise drop the byte and set load_ovf.
  - ptr += 1 and rem -= 1.
- LOAD, handshake with rem == 1: go to IDLE and pulse load_done the following cycle.
- LOAD, ld_valid=0: hold state; the stall may be of any length.
- load_start is ignored while in LOAD.
- ptr increments modulo 2^ADDR_W. Range compares use ADDR_W+1-bit arithmetic, so no false in-range result can come from wrap.
- Fetch:
  - fetch_req in cycle N gives fetch_valid=1 in cycle N+1.
  - fetch_data and fetch_fault are registered; back-to-back requests are allowed at one per cycle.
- fetch_fault = 1 when any of the following holds:
  - fetch_addr + WORD_BYTES > DEPTH (evaluated in ADDR_W+1 bits);
  - the request was sampled while load_busy=1.
- When fetch_fault=1, fetch_data = 0.
- Unaligned addresses are legal and are not a fault.
- When fetch_req=0, fetch_valid=0 next cycle and fetch_data holds its last value.
- A fetch in the same cycle as the final load byte is accepted normally. load_busy is already low in the next cycle, and the fetch sees the updated byte: write first, then read.
- Reset mid-load:
  - FSM returns to IDLE with no load_done pulse;
  - bytes already written keep their values;
  - any in-flight fetch_valid is cleared.

Decomposition:
- Shared package instr_mem_pkg:
  - typedef load_state_t {LS_IDLE, LS_LOAD};
  - localparam WORD_W = 8*WORD_BYTES;
  - function in_range(addr, nbytes, depth).
- Sub-module byte_ram:
  - DEPTH x 8 storage;
  - one synchronous byte write port;
  - WORD_BYTES-wide combinational read at base address, assembling little-endian.
- The top module holds the FSM, counters and fetch registers.

Test Plan:
- Stream load: load_base=0x10, load_len=4, bytes 0x13,0x05,0x10,0x00 with two idle ld_valid cycles inserted. Then fetch 0x10 -> fetch_data=0x00100513 one cycle later, fetch_fault=0, load_done pulsed exactly once.
- Unaligned fetch after loading 0x00..0x07 with 0x11..0x88: fetch 0x02 -> 0x66554433.
- Range boundary, DEPTH=1024:
  - fetch 0x3FC -> fault=0;
  - fetch 0x3FD -> fault=1, data=0;
  - fetch 0xFFFFFFFE -> fault=1 (no wrap).
- Overflow load: load_base=0x3FE, load_len=4, bytes 0xAA..0xDD. Result: mem[0x3FE]=0xAA, mem[0x3FF]=0xBB, load_ovf=1, load_done pulses, and the next load_start clears load_ovf.
- Zero-length and busy conditions:
  - load_len=0 -> load_done next cycle, load_busy never asserts.
  - fetch during LOAD -> fetch_valid=1, fetch_fault=1.
  - second load_start during LOAD -> ignored (rem unchanged).
- Reset after 2 of 4 bytes of a session:
  - outputs return to reset values and no load_done is seen;
  - the 2 written bytes persist when read by a later fetch.
